// File: rtl/seg_led_pkg.sv
// Shared definitions for the seven-segment bus receive path.
//   - 7-bit segment codes (g..a, active-low, dp excluded) for hex digits 0..F
//   - SEG_BLANK: all segments dark
//   - receiver FSM state type
//   - default parameter values and the matching counter width
package seg_led_pkg;

    localparam int STABLE_CYC_DEF = 4;
    localparam int NUM_DIG_DEF    = 6;
    localparam int CNT_W          = $clog2(STABLE_CYC_DEF + 1);

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of a seven-segment pattern.
// Ports:
//   pat      in   7   segment lines g..a, active-low (dp not included)
//   hit      out  1   pattern is one of the 16 hex glyphs
//   is_blank out  1   pattern is all segments off
//   val      out  4   hex value of the glyph (0 when not a hit)
module seg7_pattern_decode
    import seg_led_pkg::*;
(
    input  logic [6:0] pat,
    output logic       hit,
    output logic       is_blank,
    output logic [3:0] val
);

    always_comb begin
        hit      = 1'b1;
        is_blank = 1'b0;
        val      = 4'h0;
        case (pat)
            SEG_0:     val = 4'h0;
            SEG_1:     val = 4'h1;
            SEG_2:     val = 4'h2;
            SEG_3:     val = 4'h3;
            SEG_4:     val = 4'h4;
            SEG_5:     val = 4'h5;
            SEG_6:     val = 4'h6;
            SEG_7:     val = 4'h7;
            SEG_8:     val = 4'h8;
            SEG_9:     val = 4'h9;
            SEG_A:     val = 4'hA;
            SEG_B:     val = 4'hB;
            SEG_C:     val = 4'hC;
            SEG_D:     val = 4'hD;
            SEG_E:     val = 4'hE;
            SEG_F:     val = 4'hF;
            SEG_BLANK: begin
                hit      = 1'b0;
                is_blank = 1'b1;
            end
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_led_decoder.sv
// Receive side of the multiplexed seven-segment bus. Samples sel/seg_led,
// waits for STABLE_CYC consecutive matching samples, then decodes the
// pattern into every selected digit slot of a small register file.
// Ports:
//   clk      in   1           system clock (rising edge)
//   rst      in   1           asynchronous active-high reset
//   sel      in   NUM_DIG     digit select, active-low
//   seg_led  in   8           segments, active-low, [7]=dp, [6:0]=g..a
//   err_clr  in   1           clears sticky err
//   digits   out  4*NUM_DIG   decoded hex per digit
//   dp       out  NUM_DIG     decimal point lit per digit
//   valid    out  NUM_DIG     digit holds a legal hex glyph
//   blank    out  NUM_DIG     digit holds the all-off pattern
//   upd      out  1           one-cycle pulse per commit
//   err      out  1           sticky illegal-pattern flag
//   err_cnt  out  8           saturating illegal-commit count
//
// state | meaning
// IDLE  | bus deselected (sel all-ones), nothing to commit
// TRACK | input changed, counting stable samples
// HOLD  | current value committed, waiting for a change
module seg_led_decoder
    import seg_led_pkg::*;
#(
    parameter int STABLE_CYC = STABLE_CYC_DEF,
    parameter int NUM_DIG    = NUM_DIG_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DIG-1:0]     sel,
    input  logic [7:0]             seg_led,
    input  logic                   err_clr,
    output logic [4*NUM_DIG-1:0]   digits,
    output logic [NUM_DIG-1:0]     dp,
    output logic [NUM_DIG-1:0]     valid,
    output logic [NUM_DIG-1:0]     blank,
    output logic                   upd,
    output logic                   err,
    output logic [7:0]             err_cnt
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int SW = NUM_DIG + 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [SW-1:0]        samp_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    state_t               state_q, state_d;
    logic [4*NUM_DIG-1:0] digits_q, digits_d;
    logic [NUM_DIG-1:0]   dp_q, dp_d, valid_q, valid_d, blank_q, blank_d;
    logic                 upd_q, err_q, err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic [SW-1:0] in_w;
    logic          same, sel_idle, commit, illegal;
    logic          hit, is_blank;
    logic [3:0]    val;

    assign in_w     = {sel, seg_led};
    assign same     = (in_w == samp_q);
    assign sel_idle = &sel;

    // At commit the live input equals the sample, so decoding the live
    // pattern is the same as decoding the committed one.
    seg7_pattern_decode u_dec (
        .pat      (seg_led[6:0]),
        .hit      (hit),
        .is_blank (is_blank),
        .val      (val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!same) begin
            cnt_d   = '0;
            state_d = TRACK;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            if (state_q == TRACK && cnt_q == CNT_MAX) begin
                if (sel_idle) begin
                    state_d = IDLE;
                end else begin
                    commit  = 1'b1;
                    state_d = HOLD;
                end
            end
        end
    end

    assign illegal = commit && !hit && !is_blank;

    always_comb begin
        digits_d  = digits_q;
        dp_d      = dp_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (commit) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                if (!sel[i]) begin
                    digits_d[4*i +: 4] = hit ? val : 4'h0;
                    dp_d[i]            = ~seg_led[7];
                    valid_d[i]         = hit;
                    blank_d[i]         = is_blank;
                end
            end
        end
        // A fresh error outranks a clear arriving on the same edge.
        if (illegal) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q    <= '1;
            cnt_q     <= '0;
            state_q   <= IDLE;
            digits_q  <= '0;
            dp_q      <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            samp_q    <= in_w;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            upd_q     <= commit;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign digits  = digits_q;
    assign dp      = dp_q;
    assign valid   = valid_q;
    assign blank   = blank_q;
    assign upd     = upd_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_led_decoder.sv
// Scoreboard bench for seg_led_decoder: stimulus updates a behavioural model
// (run-length of identical samples + per-digit arrays) and queues expected
// snapshots; an independent monitor compares them on the falling edge.
module tb_seg_led_decoder;

    localparam int STABLE = 4;
    localparam int ND     = 6;

    localparam logic [7:0] CODE8 [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [ND-1:0] sel = '1;
    logic [7:0]    seg_led = 8'hFF;
    logic          err_clr = 1'b0;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] dp, valid, blank;
    logic          upd, err;
    logic [7:0]    err_cnt;

    seg_led_decoder #(.STABLE_CYC(STABLE), .NUM_DIG(ND)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .seg_led (seg_led),
        .err_clr (err_clr),
        .digits  (digits),
        .dp      (dp),
        .valid   (valid),
        .blank   (blank),
        .upd     (upd),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*ND-1:0] dig;
        logic [ND-1:0]   dpv;
        logic [ND-1:0]   vl;
        logic [ND-1:0]   bl;
        logic            er;
        logic [7:0]      ec;
        logic            up;
    } exp_t;

    exp_t exp_q[$];

    // behavioural model state
    logic [3:0]  m_dig [ND];
    logic [ND-1:0] m_dp, m_vl, m_bl;
    logic        m_err;
    int          m_ecnt;
    logic [ND+7:0] m_prev;
    int          m_run;
    bit          last_commit;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int lookup(input logic [7:0] g);
        int idx = -1;
        for (int k = 0; k < 16; k++)
            if ((g | 8'h80) == CODE8[k]) idx = k;
        return idx;
    endfunction

    function automatic exp_t snap(input logic up);
        exp_t e;
        for (int i = 0; i < ND; i++) e.dig[4*i +: 4] = m_dig[i];
        e.dpv = m_dp;
        e.vl  = m_vl;
        e.bl  = m_bl;
        e.er  = m_err;
        e.ec  = 8'(m_ecnt);
        e.up  = up;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
        m_dp = '0; m_vl = '0; m_bl = '0;
        m_err = 1'b0; m_ecnt = 0;
        m_prev = '1; m_run = 0;
        last_commit = 1'b0;
    endtask

    // One clock edge as seen by the model: a value commits once it has been
    // present on STABLE+1 consecutive edges while some digit is selected.
    task automatic model_edge(input logic [ND-1:0] s, input logic [7:0] g, input logic c);
        logic [ND+7:0] in_v;
        bit commit, bad;
        int idx;
        in_v = {s, g};
        if (in_v != m_prev) m_run = 1;
        else m_run = m_run + 1;
        m_prev = in_v;
        commit = (m_run == STABLE + 1) && (s != '1);
        bad = 1'b0;
        if (commit) begin
            idx = lookup(g);
            bad = (idx < 0) && (g[6:0] != 7'h7F);
            for (int i = 0; i < ND; i++) begin
                if (!s[i]) begin
                    m_dig[i] = (idx >= 0) ? 4'(idx) : 4'h0;
                    m_dp[i]  = ~g[7];
                    m_vl[i]  = (idx >= 0);
                    m_bl[i]  = (g[6:0] == 7'h7F);
                end
            end
        end
        if (bad) begin
            m_err = 1'b1;
            if (m_ecnt < 255) m_ecnt = m_ecnt + 1;
        end else if (c) begin
            m_err = 1'b0;
        end
        last_commit = commit;
        if (commit) exp_q.push_back(snap(1'b1));
    endtask

    task automatic step(input logic [ND-1:0] s, input logic [7:0] g, input logic c);
        sel = s; seg_led = g; err_clr = c;
        @(posedge clk);
        model_edge(s, g, c);
        #1;
    endtask

    task automatic hold(input logic [ND-1:0] s, input logic [7:0] g, input int n);
        for (int k = 0; k < n; k++) step(s, g, 1'b0);
    endtask

    task automatic probe();
        if (!last_commit) exp_q.push_back(snap(1'b0));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        exp_q.push_back(snap(1'b0));
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_assert++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    // monitor: sole owner of the pass/fail counters
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("upd",     32'(upd),     32'(e.up));
                chk("digits",  32'(digits),  32'(e.dig));
                chk("dp",      32'(dp),      32'(e.dpv));
                chk("valid",   32'(valid),   32'(e.vl));
                chk("blank",   32'(blank),   32'(e.bl));
                chk("err",     32'(err),     32'(e.er));
                chk("err_cnt", 32'(err_cnt), 32'(e.ec));
            end else if (upd) begin
                chk("upd_unexpected", 32'(upd), 32'd0);
            end
        end
    end

    initial begin
        logic [ND-1:0] s;
        logic [7:0]    g;
        int            r;

        // reset with arbitrary inputs, then release deselected
        sel = 6'h15; seg_led = 8'h5A; err_clr = 1'b1;
        apply_reset();
        hold(6'h3F, 8'hFF, 6);
        probe();

        // single digit, full latency
        hold(6'h3E, 8'hA4, 5);
        hold(6'h3E, 8'hA4, 3);
        probe();

        // glitchy value replaced before it settles
        hold(6'h3E, 8'hA4, 3);
        hold(6'h3E, 8'hB0, 5);
        hold(6'h3E, 8'hB0, 2);
        probe();

        // all digits at once, dp lit, then deselect
        hold(6'h00, 8'h0E, 5);
        hold(6'h3F, 8'hFF, 6);
        probe();

        // blank, illegal, clear interactions
        hold(6'h3D, 8'hFF, 5);
        hold(6'h3D, 8'hAA, 5);
        hold(6'h3D, 8'hFF, 5);
        hold(6'h3D, 8'hAA, 4);
        step(6'h3D, 8'hAA, 1'b1);
        step(6'h3D, 8'hAA, 1'b1);
        probe();

        // sweep every glyph on digit 5 with dp toggling
        for (int k = 0; k < 16; k++) begin
            g = CODE8[k];
            if (k[0]) g[7] = 1'b0;
            hold(6'h1F, g, 5);
        end

        // change on the would-be commit edge
        hold(6'h1F, 8'hF9, 4);
        hold(6'h1F, 8'hC0, 5);

        // reset while counting, then hold long enough to commit afresh
        hold(6'h1F, 8'h99, 3);
        apply_reset();
        hold(6'h1F, 8'h99, 3);
        probe();
        hold(6'h1F, 8'h99, 3);
        probe();

        // randomized phase
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      s = ~(6'b1 << $urandom_range(0, ND - 1));
            else if (r < 9) s = 6'($urandom);
            else            s = '1;
            r = $urandom_range(0, 9);
            if (r < 7) begin
                g = CODE8[$urandom_range(0, 15)];
                if ($urandom_range(0, 1) == 1) g[7] = 1'b0;
            end else if (r == 7) begin
                g = {1'($urandom), 7'h7F};
            end else begin
                g = 8'($urandom);
                while (lookup(g) >= 0 || g[6:0] == 7'h7F) g = 8'($urandom);
            end
            r = $urandom_range(1, 7);
            for (int h = 0; h < r; h++) step(s, g, ($urandom_range(0, 15) == 0));
            probe();
        end

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
